// File: rtl/fadd_pkg.sv
// Shared constants for the FADD unit: IEEE-754 single field widths and
// well-known packed encodings used by the alignment and normalise stages.
package fadd_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int SUM_W     = 32;
  localparam int EXPA_W    = FP_EXP_W + 2;

  localparam int EXP_BIAS  = 127;
  localparam int EXP_MAX   = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter. The count is only meaningful
// when all_zero is low; for an all-zero input it reads 0.
module lzc32 (
  input  logic [31:0] value,
  output logic [4:0]  count,
  output logic        all_zero
);

  // Scan upward so the most significant set bit is the last one written
  always_comb begin
    count = '0;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) begin
        count = 5'(31 - i);
      end
    end
  end

  assign all_zero = ~|value;

endmodule

// File: rtl/fadd_norm_round.sv
// Normalise / round / pack stage of the FADD pipe. Stage 1 normalises the
// raw mantissa sum, stage 2 applies round-to-nearest-even and packs the
// IEEE-754 result. Both stages use a valid/ready skid-free handshake so the
// pipe can stall from writeback without bubbles at full throughput.
module fadd_norm_round
  import fadd_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MANT_W = FP_MANT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [SUM_W-1:0]        in_sum,
  input  logic                    in_cout,
  input  logic                    in_special,
  input  logic [EXP_W+MANT_W:0]   in_special_val,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   out_result,
  output logic                    out_overflow,
  output logic                    out_underflow,
  output logic                    out_inexact
);

  // Adjusted exponent carries two extra bits and is treated as two's
  // complement so exp-31 and exp+2 never wrap.
  localparam int XW       = EXP_W + 2;
  localparam int RES_W    = EXP_W + MANT_W + 1;
  localparam int SIG_W    = MANT_W + 1;
  localparam int GRD      = SUM_W - SIG_W - 1;
  localparam int EXP_ONES = (1 << EXP_W) - 1;

  // Stage 1 registers
  logic             s1_valid;
  logic             s1_sign;
  logic [XW-1:0]    s1_exp;
  logic [SUM_W-1:0] s1_norm;
  logic             s1_sticky;
  logic             s1_zero;
  logic             s1_special;
  logic [RES_W-1:0] s1_special_val;

  // Handshake
  logic in_fire;
  logic s1_advance;

  // Stage 1 combinational results
  logic [4:0]       lz;
  logic             sum_zero;
  logic [XW-1:0]    exp_ext;
  logic [XW-1:0]    lz_ext;
  logic [SUM_W-1:0] n1_norm;
  logic [XW-1:0]    n1_exp;
  logic             n1_sticky;
  logic             n1_zero;

  // Stage 2 combinational results
  logic [SIG_W-1:0] sig;
  logic             guard_bit;
  logic             sticky_bit;
  logic             round_up;
  logic [SIG_W:0]   sig_rnd;
  logic [XW-1:0]    exp_rnd;
  logic [MANT_W-1:0] frac;
  logic             is_ovf;
  logic             is_unf;
  logic [RES_W-1:0] r_result;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_inexact;

  assign s1_advance = s1_valid & (~out_valid | out_ready);
  assign in_ready   = ~s1_valid | s1_advance;
  assign in_fire    = in_valid & in_ready;

  lzc32 u_lzc (
    .value    (in_sum),
    .count    (lz),
    .all_zero (sum_zero)
  );

  assign exp_ext = {2'b00, in_exp};
  assign lz_ext  = {{(XW-5){1'b0}}, lz};

  // Normalise: a carry-out shifts right by one, otherwise shift left by the
  // leading-zero count; an all-zero sum with no carry is an exact zero
  always_comb begin
    n1_norm   = in_sum << lz;
    n1_exp    = exp_ext - lz_ext;
    n1_sticky = 1'b0;
    n1_zero   = 1'b0;
    if (in_cout) begin
      n1_norm   = {1'b1, in_sum[SUM_W-1:1]};
      n1_exp    = exp_ext + XW'(1);
      n1_sticky = in_sum[0];
    end else if (sum_zero) begin
      n1_zero = 1'b1;
    end
  end

  // Stage 1 register: load on accept, drain when stage 2 takes the beat
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_sign        <= 1'b0;
      s1_exp         <= '0;
      s1_norm        <= '0;
      s1_sticky      <= 1'b0;
      s1_zero        <= 1'b0;
      s1_special     <= 1'b0;
      s1_special_val <= '0;
    end else if (in_fire) begin
      s1_valid       <= 1'b1;
      s1_sign        <= in_sign;
      s1_exp         <= n1_exp;
      s1_norm        <= n1_norm;
      s1_sticky      <= n1_sticky;
      s1_zero        <= n1_zero;
      s1_special     <= in_special;
      s1_special_val <= in_special_val;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Round to nearest even, fold the rounding carry into the exponent,
  // then pick the packed result by priority: special, zero, ovf, unf, normal
  always_comb begin
    sig        = s1_norm[SUM_W-1 -: SIG_W];
    guard_bit  = s1_norm[GRD];
    sticky_bit = (|s1_norm[GRD-1:0]) | s1_sticky;
    round_up   = guard_bit & (sticky_bit | sig[0]);
    sig_rnd    = {1'b0, sig} + {{SIG_W{1'b0}}, round_up};
    exp_rnd    = s1_exp;
    frac       = sig_rnd[MANT_W-1:0];
    if (sig_rnd[SIG_W]) begin
      exp_rnd = s1_exp + XW'(1);
      frac    = '0;
    end
    is_ovf = ~exp_rnd[XW-1] & (exp_rnd >= XW'(EXP_ONES));
    is_unf = exp_rnd[XW-1] | (exp_rnd == '0);

    r_result    = {s1_sign, exp_rnd[EXP_W-1:0], frac};
    r_overflow  = 1'b0;
    r_underflow = 1'b0;
    r_inexact   = guard_bit | sticky_bit;
    if (s1_special) begin
      r_result  = s1_special_val;
      r_inexact = 1'b0;
    end else if (s1_zero) begin
      r_result  = '0;
      r_inexact = 1'b0;
    end else if (is_ovf) begin
      r_result   = {s1_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      r_overflow = 1'b1;
      r_inexact  = 1'b1;
    end else if (is_unf) begin
      r_result    = {s1_sign, {(RES_W-1){1'b0}}};
      r_underflow = 1'b1;
      r_inexact   = 1'b1;
    end
  end

  // Output register: holds its beat while downstream stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (s1_advance) begin
      out_valid     <= 1'b1;
      out_result    <= r_result;
      out_overflow  <= r_overflow;
      out_underflow <= r_underflow;
      out_inexact   <= r_inexact;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fadd_norm_round.md
Name: fadd_norm_round

Overview:
Downstream stage of the pipelined 32-bit mantissa adder in the FADD unit. It consumes the adder's raw 32-bit sum and carry-out, plus the sign and exponent carried alongside. It normalises the sum with a leading-zero count and shift, applies round-to-nearest-even, and packs an IEEE-754 single-precision result. Two pipeline stages with a valid/ready handshake, so the FADD pipe can stall from writeback.

Parameters:
EXP_W, 8, IEEE exponent width; internal adjusted exponent is EXP_W+2 bits signed.
MANT_W, 23, stored fraction width; significand = MANT_W+1 bits.

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_sign  input  1  result sign from alignment stage
in_exp  input  8  biased exponent of the larger operand
in_sum  input  32  adder sum; hidden-bit position is bit 31, bits 7:0 hold guard/round/sticky bits
in_cout  input  1  adder carry-out (weight 2^32)
in_special  input  1  NaN/Inf/zero-operand bypass flag from upstream
in_special_val  input  32  packed result used when in_special=1
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_result  output  32  packed IEEE-754 single
out_overflow  output  1  result overflowed to infinity
out_underflow  output  1  result flushed to zero
out_inexact  output  1  rounding discarded nonzero bits

Behaviour:
- Reset: out_valid=0, out_result=0, all flags=0, both stage valids cleared. in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards in-flight beats.
- Handshake: a beat transfers on in_valid&in_ready, or on out_valid&out_ready. Stage advances when its successor is empty or is advancing. in_ready = ~s1_valid | s1_advance. No bubbles at full throughput. Latency is 2 cycles, in-transfer to out_valid. While out_valid=1 and out_ready=0, out_* hold stable.
- Stage 1 (normalise):
  - cout=1: N = {1, in_sum[31:1]}; exp_adj = exp+1; the shifted-out in_sum[0] is ORed into sticky.
  - cout=0 and in_sum≠0: lz = leading zeros of in_sum (0..31); N = in_sum<<lz; exp_adj = exp−lz.
  - cout=0 and in_sum=0: exact-zero flag set.
- Stage 2 (round/pack):
  - sig = N[31:8], G = N[7], S = |N[6:0] | sticky1.
  - Round up when G & (S | sig[0]). inexact = G|S.
  - Round carry (sig=0xFFFFFF, up): sig = 0x800000, exp_adj+1.
  - exp_adj ≥ 255: result = {sign, 0xFF, 0}, overflow=1, inexact=1.
  - exp_adj ≤ 0: result = {sign, 31'b0}, underflow=1, inexact=1 (no denormals).
  - Exact zero: result = +0 (0x00000000), flags 0.
  - Otherwise result = {sign, exp_adj[7:0], sig[22:0]}.
- Special: in_special=1 passes in_special_val through both stages unchanged, flags 0, same latency and order.
- Exponent arithmetic is 10-bit signed, so exp−31 and exp+2 never wrap.

Decomposition:
- Shared package fadd_pkg: EXP_BIAS=127, EXP_MAX=255, QNAN=0x7FC00000, POS_INF=0x7F800000, widths.
- One sub-module, lzc32: combinational 32-bit leading-zero counter. Outputs a 5-bit count and an all-zero flag. Reusable by the alignment stage.

Test Plan:
- 1.0+1.0: exp=127, cout=1, sum=0x00000000 -> out_result=0x40000000, 2 cycles later, flags 0.
- Cancellation: exp=127, cout=0, sum=0x00800000 -> lz=8 -> 0x3B800000, inexact=0.
- RNE ties: sum=0x80000180, exp=127 -> 0x3F800002, inexact=1. sum=0x80000080 -> 0x3F800000, inexact=1.
- Round carry: sum=0xFFFFFF80, exp=127 -> 0x40000000. Overflow: exp=254, cout=1 -> 0x7F800000, overflow=1. Underflow: exp=5, sum=0x00000100 -> 0x00000000, underflow=1.
- Backpressure: 4 back-to-back beats with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, out_result held stable. Release -> all 4 emerge in order, none lost or duplicated.
- Special and reset: in_special=1, val=0x7FC00000 interleaved with normal beats -> passes through in order. Assert reset with 2 beats in flight -> next cycle out_valid=0, no stale output after reset.
